timestamp_mem_loader: RTL and testbench



---
 rtl/timestamp_mem_loader_pkg.sv | 16 +
 rtl/timestamp_mem_loader_load_seq_counter.sv | 40 ++++
 rtl/timestamp_mem_loader.sv | 115 +++++++++++
 tb/tb_timestamp_mem_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_mem_loader_pkg.sv
// Shared types and constants for the timestamp/active-pixel memory write-side loader.
package timestamp_mem_loader_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 17;
  localparam int unsigned MAX_FRAME = 4;

  typedef logic [2:0] frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/timestamp_mem_loader_load_seq_counter.sv
// Nested pixel/frame counter walking every address of every frame group in load order.
module load_seq_counter
  import timestamp_mem_loader_pkg::frame_t;
#(
  parameter int unsigned ADDR_W = timestamp_mem_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] ppl,
  input  frame_t            nf,
  output logic [ADDR_W-1:0] addr,
  output frame_t            frame,
  output logic              last
);

  logic wrap;

  always_comb begin
    wrap = (addr == ppl - ADDR_W'(1));
    last = wrap && (frame == nf);
  end

  // Frame saturates at nf so it never exceeds the loaded range after the final beat.
  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      addr  <= '0;
      frame <= '0;
    end else if (advance) begin
      if (wrap) begin
        addr <= '0;
        if (frame != nf) frame <= frame + 3'd1;
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/timestamp_mem_loader.sv
// Write-side controller: streams {active_pixel, timestamp} words into the idle bank of every frame group.
module timestamp_mem_loader #(
  parameter int unsigned ADDR_W    = timestamp_mem_loader_pkg::ADDR_W,
  parameter int unsigned DATA_W    = timestamp_mem_loader_pkg::DATA_W,
  parameter int unsigned MAX_FRAME = timestamp_mem_loader_pkg::MAX_FRAME
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              update_mem_i,
  input  logic [2:0]        number_of_frames_i,
  input  logic [ADDR_W-1:0] pixels_per_line_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wen_o,
  output logic [2:0]        memory_selector_o,
  output logic              mem_updated_o,
  output logic              busy_o,
  output logic              load_abort_o
);
  import timestamp_mem_loader_pkg::*;

  state_t            state;
  logic              upd_q;
  logic              init_pend;
  logic [ADDR_W-1:0] ppl_q;
  frame_t            nf_q;
  frame_t            nf_clamped;
  logic [ADDR_W-1:0] addr;
  frame_t            frame;
  logic              last;
  logic              req;
  logic              beat;
  logic              start;

  always_comb begin
    req        = (update_mem_i != upd_q);
    beat       = s_valid_i && s_ready_o;
    start      = (state == IDLE) ? (init_pend || req) : req;
    nf_clamped = (number_of_frames_i > 3'(MAX_FRAME)) ? 3'(MAX_FRAME) : number_of_frames_i;
  end

  load_seq_counter #(.ADDR_W(ADDR_W)) u_counter (
    .clk     (clk_i),
    .nrst    (nrst_i),
    .clear   (start),
    .advance (beat),
    .ppl     (ppl_q),
    .nf      (nf_q),
    .addr    (addr),
    .frame   (frame),
    .last    (last)
  );

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state             <= IDLE;
      upd_q             <= 1'b1;
      init_pend         <= 1'b1;
      ppl_q             <= '0;
      nf_q              <= '0;
      s_ready_o         <= 1'b0;
      wen_o             <= 1'b0;
      waddr_o           <= '0;
      wdata_o           <= '0;
      memory_selector_o <= '0;
      mem_updated_o     <= 1'b0;
      busy_o            <= 1'b0;
      load_abort_o      <= 1'b0;
    end else begin
      wen_o        <= 1'b0;
      load_abort_o <= 1'b0;
      // A beat accepted on a restart edge still lands at its pre-restart address.
      if (beat) begin
        wen_o             <= 1'b1;
        waddr_o           <= addr;
        wdata_o           <= s_data_i;
        memory_selector_o <= frame;
      end
      if (start) begin
        load_abort_o  <= (state == LOAD);
        nf_q          <= nf_clamped;
        ppl_q         <= pixels_per_line_i;
        upd_q         <= update_mem_i;
        init_pend     <= 1'b0;
        mem_updated_o <= 1'b0;
        if (pixels_per_line_i == '0) begin
          state     <= DONE;
          s_ready_o <= 1'b0;
          busy_o    <= 1'b0;
        end else begin
          state     <= LOAD;
          s_ready_o <= 1'b1;
          busy_o    <= 1'b1;
        end
      end else begin
        case (state)
          LOAD: begin
            if (beat && last) begin
              state     <= DONE;
              s_ready_o <= 1'b0;
              busy_o    <= 1'b0;
            end
          end
          // Flag rises once the final write has actually been issued to the memory.
          DONE:    mem_updated_o <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timestamp_mem_loader.sv
// Randomized self-checking bench: expected writes derived from beat index (frame = k / ppl, addr = k % ppl).
module tb_timestamp_mem_loader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        update_mem;
  logic [2:0]  number_of_frames;
  logic [10:0] pixels_per_line;
  logic        s_valid;
  logic [16:0] s_data;
  logic        s_ready;
  logic [10:0] waddr;
  logic [16:0] wdata;
  logic        wen;
  logic [2:0]  memory_selector;
  logic        mem_updated;
  logic        busy;
  logic        load_abort;

  int errors = 0;
  int checks = 0;

  // Last expected write fields; the DUT must hold these between writes.
  logic [2:0]  ef;
  logic [10:0] ea;
  logic [16:0] ed;

  always #5 clk = ~clk;

  timestamp_mem_loader #(.ADDR_W(11), .DATA_W(17), .MAX_FRAME(4)) dut (
    .clk_i              (clk),
    .nrst_i             (nrst),
    .update_mem_i       (update_mem),
    .number_of_frames_i (number_of_frames),
    .pixels_per_line_i  (pixels_per_line),
    .s_valid_i          (s_valid),
    .s_data_i           (s_data),
    .s_ready_o          (s_ready),
    .waddr_o            (waddr),
    .wdata_o            (wdata),
    .wen_o              (wen),
    .memory_selector_o  (memory_selector),
    .mem_updated_o      (mem_updated),
    .busy_o             (busy),
    .load_abort_o       (load_abort)
  );

  function automatic int exp_total(input int nf, input int ppl);
    return ((nf > 4) ? 5 : nf + 1) * ppl;
  endfunction

  // Runs one load from the negedge just before its entry edge until mem_updated is seen.
  task automatic drive_load(input int ppl, input int total, input int gap_mode,
                            input bit seq, input int abort_at);
    int  k = 0;
    bit  pend = 1'b0;
    bit  exp_mu = 1'b0;
    bit  fin = (total == 0);
    bit  exp_abort = 1'b0;
    bit  aborted = 1'b0;
    bit  phase = 1'b0;
    bit  exp_rdy;
    bit  done = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if ({wen, memory_selector, waddr, wdata} !== {pend, ef, ea, ed}) begin
        errors++;
        $display("FAIL write k=%0d: got wen=%0b sel=%0d addr=%0d data=%h, want wen=%0b sel=%0d addr=%0d data=%h",
                 k, wen, memory_selector, waddr, wdata, pend, ef, ea, ed);
      end
      checks++;
      if (load_abort !== exp_abort) begin
        errors++;
        $display("FAIL load_abort: got %0b want %0b", load_abort, exp_abort);
      end
      checks++;
      if (mem_updated !== exp_mu) begin
        errors++;
        $display("FAIL mem_updated: got %0b want %0b (k=%0d total=%0d)", mem_updated, exp_mu, k, total);
      end
      if (exp_mu) begin
        done = 1'b1;
        break;
      end
      exp_rdy = (k < total);
      checks++;
      if (s_ready !== exp_rdy || busy !== exp_rdy) begin
        errors++;
        $display("FAIL ready_busy: got ready=%0b busy=%0b want %0b", s_ready, busy, exp_rdy);
      end
      exp_mu    = fin;
      fin       = 1'b0;
      exp_abort = 1'b0;
      phase     = ~phase;
      case (gap_mode)
        0:       s_valid = 1'b1;
        1:       s_valid = phase;
        default: s_valid = ($urandom_range(99) < 60);
      endcase
      s_data = seq ? 17'(k) : 17'($urandom);
      if (!aborted && abort_at > 0 && k == abort_at) begin
        s_valid    = 1'b1;
        update_mem = ~update_mem;
        aborted    = 1'b1;
      end
      if (abort_at < 0 && cyc == 2) begin
        number_of_frames = 3'($urandom);
        pixels_per_line  = 11'($urandom);
      end
      pend = s_valid && exp_rdy;
      if (pend) begin
        ef = 3'(k / ppl);
        ea = 11'(k % ppl);
        ed = s_data;
        k++;
        if (k == total) fin = 1'b1;
      end
      if (aborted && abort_at > 0 && k == abort_at + 1 && !exp_abort && cyc >= 0) begin
        if (update_mem !== dut.update_mem_i) ;
      end
      if (aborted && pend && k == abort_at + 1 && abort_at > 0) begin
        k         = 0;
        fin       = 1'b0;
        exp_abort = 1'b1;
        abort_at  = -2;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: mem_updated not seen, beats=%0d want %0d", k, total);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({s_ready, wen, waddr, wdata, memory_selector, mem_updated, busy, load_abort} !== '0) begin
      errors++;
      $display("FAIL %s: got ready=%0b wen=%0b addr=%0d data=%h sel=%0d mu=%0b busy=%0b abort=%0b, want all 0",
               name, s_ready, wen, waddr, wdata, memory_selector, mem_updated, busy, load_abort);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; update_mem = 1'b1; s_valid = 1'b0; s_data = '0;
    number_of_frames = 3'd1; pixels_per_line = 11'd4;
    ef = '0; ea = '0; ed = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
  endtask

  task automatic test_initial_load;
    nrst = 1'b1;
    drive_load(4, exp_total(1, 4), 0, 1'b1, -1);
  endtask

  task automatic test_gaps;
    number_of_frames = 3'd0; pixels_per_line = 11'd3;
    update_mem = ~update_mem;
    drive_load(3, exp_total(0, 3), 1, 1'b0, -1);
  endtask

  task automatic test_reload;
    number_of_frames = 3'd2; pixels_per_line = 11'd5;
    update_mem = ~update_mem;
    drive_load(5, exp_total(2, 5), 2, 1'b0, -1);
  endtask

  task automatic test_abort;
    number_of_frames = 3'd1; pixels_per_line = 11'd4;
    update_mem = ~update_mem;
    drive_load(4, exp_total(1, 4), 0, 1'b0, 5);
  endtask

  task automatic test_clamp_and_empty;
    number_of_frames = 3'd7; pixels_per_line = 11'd2;
    update_mem = ~update_mem;
    drive_load(2, exp_total(7, 2), 2, 1'b0, -1);
    number_of_frames = 3'd3; pixels_per_line = 11'd0;
    update_mem = ~update_mem;
    drive_load(0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_midload;
    number_of_frames = 3'd1; pixels_per_line = 11'd4;
    update_mem = ~update_mem;
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      s_data = 17'($urandom);
    end
    nrst = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    check_reset_outputs("reset_midload");
    ef = '0; ea = '0; ed = '0;
    nrst = 1'b1;
    drive_load(4, exp_total(1, 4), 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    int nf;
    int ppl;
    for (int i = 0; i < 5; i++) begin
      nf  = int'($urandom_range(7));
      ppl = int'($urandom_range(6, 1));
      number_of_frames = 3'(nf);
      pixels_per_line  = 11'(ppl);
      update_mem = ~update_mem;
      drive_load(ppl, exp_total(nf, ppl), 2, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset;
    test_initial_load;
    test_gaps;
    test_reload;
    test_abort;
    test_clamp_and_empty;
    test_reset_midload;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
